// File: rtl/obi_mem_responder.sv
// obi_mem_responder: word-array memory behind a req/gnt/rvalid port.
// Every granted request (read or byte-enabled write) receives exactly one
// response RESP_LATENCY cycles after its grant, strictly in grant order.
// Optional feature macro: OBI_MEM_RAND_STALL_EN adds LFSR-driven random
// grant stalls so initiators see wait states.
module obi_mem_responder #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           MEM_WORDS       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned           RESP_LATENCY    = 1,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter logic [15:0]           LFSR_SEED       = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  // Parameter sanity: reject configurations the datapath cannot honour.
  if (DATA_WIDTH != 32) begin : g_chk_data_width
    $error("obi_mem_responder: DATA_WIDTH must be 32");
  end
  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_chk_mem_words
    $error("obi_mem_responder: MEM_WORDS must be a power of two >= 2");
  end
  if (RESP_LATENCY < 1 || RESP_LATENCY > 4) begin : g_chk_latency
    $error("obi_mem_responder: RESP_LATENCY must be 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_chk_outstanding
    $error("obi_mem_responder: MAX_OUTSTANDING must be 1..4");
  end
  // An all-zero seed would lock the stall LFSR up permanently.
  if (LFSR_SEED == 16'h0000) begin : g_chk_seed
    $error("obi_mem_responder: LFSR_SEED must be non-zero");
  end

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } resp_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  resp_t                 pipe [RESP_LATENCY];
  resp_t                 new_resp;
  logic [2:0]            outstanding;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;
  logic                  stall;
  logic                  accept;

  // Address decode: word offset from the base; the low two byte bits drop out.
  assign word_off = (addr_i - BASE_ADDR) >> 2;
  assign word_idx = word_off[IDX_W-1:0];
  assign in_range = (addr_i >= BASE_ADDR) && (word_off < ADDR_WIDTH'(MEM_WORDS));

`ifdef OBI_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) stepping every cycle outside reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Grant depends only on request, reset, credit and stall -- never on the payload.
  assign gnt_o  = req_i && !rst_i && (outstanding < 3'(MAX_OUTSTANDING)) && !stall;
  assign accept = req_i && gnt_o;

  // Byte-enabled write into the array; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Build the response entering the pipeline; idle slots carry all zeros.
  always_comb begin
    new_resp = '0;
    if (accept) begin
      new_resp.valid = 1'b1;
      new_resp.err   = !in_range;
      if (!we_i && in_range) begin
        new_resp.rdata = mem[word_idx];
      end
    end
  end

  // Fixed-latency response shift pipeline; reset flushes in-flight responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RESP_LATENCY); i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= new_resp;
      for (int i = 1; i < int'(RESP_LATENCY); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rvalid_o = pipe[RESP_LATENCY-1].valid;
  assign err_o    = pipe[RESP_LATENCY-1].err;
  assign rdata_o  = pipe[RESP_LATENCY-1].rdata;

  // Granted-but-unanswered credit counter; grant and response together cancel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else if (accept && !rvalid_o) begin
      outstanding <= outstanding + 3'd1;
    end else if (!accept && rvalid_o) begin
      outstanding <= outstanding - 3'd1;
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder: directed bench for obi_mem_responder.
// Instance dut uses default parameters (latency 1); dut_b uses latency 3 with
// two outstanding credits to exercise throttling and reset flushing.
// With OBI_MEM_RAND_STALL_EN defined, a random-stall scoreboard run replaces
// the directed sequence.
module tb_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0, we = 1'b0, gnt, rvalid, err;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0, rdata;

  logic        req_b = 1'b0, we_b = 1'b0, gnt_b, rvalid_b, err_b;
  logic [3:0]  be_b = 4'h0;
  logic [31:0] addr_b = '0, wdata_b = '0, rdata_b;

  int checks = 0;
  int errors = 0;

  logic [9:0]       gm, vm;
  logic [3:0][31:0] rd;
  logic             eo, stale;

  always #5 clk = ~clk;

  obi_mem_responder dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  obi_mem_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b), .be_i(be_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive dut inputs just after a rising edge, then return at the falling edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req = r; we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
  endtask

  // Hold a request on dut_b for four accesses, advancing the payload on each
  // grant, and record the per-cycle grant and response pattern over 10 cycles.
  task automatic runThrottle(input logic isWrite, output logic [9:0] gmask,
                             output logic [9:0] vmask, output logic [3:0][31:0] rdq,
                             output logic errOr);
    int idx, nr;
    idx = 0; nr = 0; gmask = '0; vmask = '0; rdq = '0; errOr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (idx < 4) begin
        req_b = 1'b1; we_b = isWrite; be_b = 4'hF;
        addr_b = 32'(idx * 4); wdata_b = 32'hB0 + 32'(idx);
      end else begin
        req_b = 1'b0;
      end
      @(negedge clk);
      if (gnt_b) begin gmask[c] = 1'b1; idx++; end
      if (rvalid_b) begin
        vmask[c] = 1'b1;
        if (nr < 4) rdq[nr] = rdata_b;
        nr++;
        errOr = errOr | err_b;
      end
    end
  endtask

`ifdef OBI_MEM_RAND_STALL_EN
  logic [15:0] lfsrModel;
  logic [31:0] goldMem [16];
  logic [32:0] expQ [$];
  logic [32:0] expEntry;
  logic        opWrite, granted;
  logic [3:0]  opBe, opIdx;
  logic [31:0] opData;
  int          grants = 0, resps = 0;

  // Reference copy of the stall LFSR, advanced on the same edges as the DUT.
  always @(posedge clk) begin
    if (rst) lfsrModel <= 16'hACE1;
    else lfsrModel <= {lfsrModel[14:0], lfsrModel[15] ^ lfsrModel[13] ^ lfsrModel[12] ^ lfsrModel[10]};
  end

  task automatic popResponse();
    if (rvalid) begin
      if (expQ.size() == 0) begin
        checkOutput("resp_unexpected", 32'd1, 32'd0);
      end else begin
        expEntry = expQ.pop_front();
        checkOutput("resp_err", {31'd0, err}, {31'd0, expEntry[32]});
        checkOutput("resp_data", rdata, expEntry[31:0]);
        resps++;
      end
    end
  endtask
`endif

  initial begin
    // Reset with a request pending: no grant, all response outputs quiet.
    req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gnt", {31'd0, gnt}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_rvalid_b", {31'd0, rvalid_b}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);

`ifdef OBI_MEM_RAND_STALL_EN
    for (int n = 0; n < 1000; n++) begin
      opWrite = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      opIdx   = (n < 16) ? 4'(n) : 4'($urandom_range(0, 15));
      opBe    = (n < 16) ? 4'hF : 4'($urandom_range(0, 15));
      opData  = $urandom;
      @(posedge clk);
      #1;
      req = 1'b1; we = opWrite; be = opBe; addr = {26'd0, opIdx, 2'b00}; wdata = opData;
      granted = 1'b0;
      for (int c = 0; c < 64 && !granted; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        @(negedge clk);
        checkOutput("stall_gnt", {31'd0, gnt}, {31'd0, (lfsrModel[1:0] != 2'b00)});
        popResponse();
        if (gnt) begin
          granted = 1'b1;
          grants++;
          if (opWrite) begin
            for (int k = 0; k < 4; k++)
              if (opBe[k]) goldMem[opIdx][8*k +: 8] = opData[8*k +: 8];
            expQ.push_back(33'd0);
          end else begin
            expQ.push_back({1'b0, goldMem[opIdx]});
          end
        end
      end
      if (!granted) checkOutput("grant_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      popResponse();
      @(posedge clk);
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("one_resp_per_grant", 32'(resps), 32'(grants));
`else
    // Write then read 0x10 back to back: same-cycle grants, one-cycle latency.
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    checkOutput("wr10_gnt", {31'd0, gnt}, 32'd1);
    checkOutput("wr10_no_rvalid_yet", {31'd0, rvalid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    checkOutput("rd10_gnt", {31'd0, gnt}, 32'd1);
    checkOutput("wr10_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("wr10_rdata", rdata, 32'd0);
    checkOutput("wr10_err", {31'd0, err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("rd10_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("rd10_rdata", rdata, 32'hDEADBEEF);
    checkOutput("rd10_err", {31'd0, err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("idle_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("idle_rdata", rdata, 32'd0);

    // Byte lanes: only lanes 0 and 2 take the second write.
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
    applyStimulus(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("be_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("be_rdata", rdata, 32'h11BB33DD);

    // be=0 write is a no-op; address bits [1:0] are ignored on the read.
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h22, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("be0_rdata", rdata, 32'h11BB33DD);

    // Out of range at 0x1000 must not alias onto word 0.
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h1000, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    checkOutput("oob_wr_rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("oob_wr_err", {31'd0, err}, 32'd1);
    checkOutput("oob_wr_rdata", rdata, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    checkOutput("oob_rd_err", {31'd0, err}, 32'd1);
    checkOutput("oob_rd_rdata", rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("word0_intact", rdata, 32'hCAFEF00D);
    checkOutput("word0_err", {31'd0, err}, 32'd0);

    // Last in-range word, then a far out-of-range address.
    applyStimulus(1'b1, 1'b1, 4'hF, 32'hFFC, 32'h0F0F0F0F);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'hFFC, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'hFFFFFFFC, 32'h0);
    checkOutput("last_word_rdata", rdata, 32'h0F0F0F0F);
    checkOutput("last_word_err", {31'd0, err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("far_oob_err", {31'd0, err}, 32'd1);
    checkOutput("far_oob_rdata", rdata, 32'd0);

    // Latency 3 with two credits: grants 0,1,4,5 and responses 3,4,7,8.
    runThrottle(1'b1, gm, vm, rd, eo);
    checkOutput("thr_wr_gnt_mask", {22'd0, gm}, 32'h033);
    checkOutput("thr_wr_rvalid_mask", {22'd0, vm}, 32'h198);
    runThrottle(1'b0, gm, vm, rd, eo);
    checkOutput("thr_rd_gnt_mask", {22'd0, gm}, 32'h033);
    checkOutput("thr_rd_rvalid_mask", {22'd0, vm}, 32'h198);
    checkOutput("thr_rd0", rd[0], 32'hB0);
    checkOutput("thr_rd1", rd[1], 32'hB1);
    checkOutput("thr_rd2", rd[2], 32'hB2);
    checkOutput("thr_rd3", rd[3], 32'hB3);
    checkOutput("thr_rd_err", {31'd0, eo}, 32'd0);

    // Reset with two reads in flight on dut_b: both responses are flushed.
    @(posedge clk); #1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h0;
    @(negedge clk);
    checkOutput("rstb_gnt0", {31'd0, gnt_b}, 32'd1);
    @(posedge clk); #1;
    addr_b = 32'h4;
    @(negedge clk);
    checkOutput("rstb_gnt1", {31'd0, gnt_b}, 32'd1);
    @(posedge clk); #1;
    req_b = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstb_rvalid_next", {31'd0, rvalid_b}, 32'd0);
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      stale = stale | rvalid_b;
    end
    checkOutput("rstb_no_stale", {31'd0, stale}, 32'd0);

    // After reset: credits restored on dut_b, array contents kept on both.
    @(posedge clk); #1;
    req_b = 1'b1; addr_b = 32'h8;
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clk);
    checkOutput("post_rst_gnt_b", {31'd0, gnt_b}, 32'd1);
    checkOutput("post_rst_gnt", {31'd0, gnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    req_b = 1'b0;
    checkOutput("post_rst_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_b_wait", {31'd0, rvalid_b}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_b_rvalid", {31'd0, rvalid_b}, 32'd1);
    checkOutput("post_rst_b_rdata", rdata_b, 32'hB2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
